// File: rtl/cpu_pkg.sv
// Shared CPU definitions: MEM-stage FSM states, bus widths, error bit indices
// and a small address alignment helper.
package cpu_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned REG_W        = 5;
  localparam int unsigned WB_W         = 2;
  localparam int unsigned ERR_W        = 2;
  localparam int unsigned ERR_MISALIGN = 0;
  localparam int unsigned ERR_TIMEOUT  = 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Word accesses must have the two low address bits clear.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait counter for outstanding memory accesses.
// Ports:
//   clk_i, rst_i : clock, async active-high reset
//   clr_i        : synchronous clear (has priority over enable)
//   en_i         : count one cycle
//   tc_o         : terminal count, high while the count equals TIMEOUT-1
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_tc;

  assign w_tc = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign tc_o = w_tc;

  // Saturates at the terminal value so it never wraps back to zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i && !w_tc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: word loads/stores over a req/ack data-memory port,
// upstream stall while an access is outstanding, registered writeback bundle,
// misaligned-address and ack-timeout error pulses.
// Ports:
//   clk_i, rst_i                      : clock, async active-high reset
//   WBsig_i, MemRead_i, MemWrite_i,
//   ALUdata_i, RS2data_i, RDaddr_i    : EX/MEM bundle
//   mem_req_o, mem_we_o, mem_addr_o,
//   mem_wdata_o, mem_ack_i, mem_rdata_i : data-memory port
//   stall_o                           : combinational upstream hold
//   WBsig_o, MemData_o, ALUdata_o,
//   RDaddr_o                          : registered MEM/WB bundle
//   err_o                             : one-cycle error pulse (bit0 misalign, bit1 timeout)
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WB_W-1:0]   WBsig_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [XLEN-1:0]   ALUdata_i,
  input  logic [XLEN-1:0]   RS2data_i,
  input  logic [REG_W-1:0]  RDaddr_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              stall_o,
  output logic [WB_W-1:0]   WBsig_o,
  output logic [XLEN-1:0]   MemData_o,
  output logic [XLEN-1:0]   ALUdata_o,
  output logic [REG_W-1:0]  RDaddr_o,
  output logic [ERR_W-1:0]  err_o
);

  state_t            r_state;
  logic [WB_W-1:0]   r_wbsig;
  logic [REG_W-1:0]  r_rd;

  logic w_access;
  logic w_misaligned;
  logic w_busy;
  logic w_tc;

  assign w_access     = MemRead_i | MemWrite_i;
  assign w_misaligned = is_misaligned(ALUdata_i);
  assign w_busy       = (r_state == BUSY);

  // Timer is held at zero in IDLE, so it starts clean for every access.
  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (!w_busy),
    .en_i  (w_busy && !mem_ack_i),
    .tc_o  (w_tc)
  );

  // Releases upstream on ack, and on the terminal wait cycle so the aborted
  // access does not hold the pipeline past the abort edge.
  assign stall_o = w_busy ? (!mem_ack_i && !w_tc)
                          : (w_access && !w_misaligned);

  // Stage FSM with registered memory port and writeback bundle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_wbsig     <= '0;
      r_rd        <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      WBsig_o     <= '0;
      MemData_o   <= '0;
      ALUdata_o   <= '0;
      RDaddr_o    <= '0;
      err_o       <= '0;
    end else begin
      err_o <= '0;
      if (r_state == IDLE) begin
        if (!w_access) begin
          WBsig_o   <= WBsig_i;
          ALUdata_o <= ALUdata_i;
          RDaddr_o  <= RDaddr_i;
        end else if (w_misaligned) begin
          WBsig_o             <= '0;
          ALUdata_o           <= ALUdata_i;
          RDaddr_o            <= RDaddr_i;
          err_o[ERR_MISALIGN] <= 1'b1;
        end else begin
          r_state     <= BUSY;
          mem_req_o   <= 1'b1;
          mem_we_o    <= MemWrite_i;
          mem_addr_o  <= {ALUdata_i[XLEN-1:2], 2'b00};
          mem_wdata_o <= RS2data_i;
          r_wbsig     <= WBsig_i;
          r_rd        <= RDaddr_i;
          WBsig_o     <= '0;
        end
      end else begin
        // Ack has priority over the timeout abort.
        if (mem_ack_i) begin
          r_state   <= IDLE;
          mem_req_o <= 1'b0;
          WBsig_o   <= r_wbsig;
          ALUdata_o <= mem_addr_o;
          RDaddr_o  <= r_rd;
          if (!mem_we_o) begin
            MemData_o <= mem_rdata_i;
          end
        end else if (w_tc) begin
          r_state            <= IDLE;
          mem_req_o          <= 1'b0;
          WBsig_o            <= '0;
          err_o[ERR_TIMEOUT] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with an expected-writeback scoreboard.
module tb_mem_access_stage;

  localparam int unsigned TIMEOUT = 16;

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] md;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [1:0]  err;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  WBsig_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] ALUdata_i;
  logic [31:0] RS2data_i;
  logic [4:0]  RDaddr_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic [1:0]  WBsig_o;
  logic [31:0] MemData_o;
  logic [31:0] ALUdata_o;
  logic [4:0]  RDaddr_o;
  logic [1:0]  err_o;

  int checks   = 0;
  int failures = 0;

  exp_t        sb[$];
  logic [31:0] m_memdata;
  logic [31:0] m_alu;
  logic [4:0]  m_rd;

  mem_access_stage #(
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .WBsig_i     (WBsig_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .ALUdata_i   (ALUdata_i),
    .RS2data_i   (RS2data_i),
    .RDaddr_i    (RDaddr_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .stall_o     (stall_o),
    .WBsig_o     (WBsig_o),
    .MemData_o   (MemData_o),
    .ALUdata_o   (ALUdata_o),
    .RDaddr_o    (RDaddr_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    MemRead_i   = 1'b0;
    MemWrite_i  = 1'b0;
    WBsig_i     = 2'b00;
    ALUdata_i   = 32'h0;
    RS2data_i   = 32'h0;
    RDaddr_i    = 5'd0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h5A5A_A5A5;
  endtask

  // Drives one EX/MEM bundle at a negedge and follows it to its writeback edge.
  // n_wait = number of BUSY cycles without ack before the ack cycle (-1: never).
  task automatic run_op(input logic rd_en, input logic wr_en, input logic [31:0] alu,
                        input logic [31:0] rs2, input logic [4:0] rd, input logic [1:0] wb,
                        input int n_wait, input logic [31:0] rdata);
    exp_t e;
    MemRead_i  = rd_en;
    MemWrite_i = wr_en;
    ALUdata_i  = alu;
    RS2data_i  = rs2;
    RDaddr_i   = rd;
    WBsig_i    = wb;
    mem_ack_i  = 1'b0;
    #1;
    if (!(rd_en || wr_en)) begin
      chk("nop_stall", stall_o, 0);
      sb.push_back('{wb, m_memdata, alu, rd, 2'b00});
    end else if (alu[1:0] != 2'b00) begin
      chk("mis_stall", stall_o, 0);
      sb.push_back('{2'b00, m_memdata, alu, rd, 2'b01});
    end else begin
      chk("arrive_stall", stall_o, 1);
      for (int cyc = 0; cyc < int'(TIMEOUT); cyc++) begin
        @(negedge clk_i);
        chk("busy_req", mem_req_o, 1);
        chk("busy_we", mem_we_o, wr_en);
        chk("busy_addr", mem_addr_o, alu);
        chk("busy_wdata", mem_wdata_o, rs2);
        chk("busy_wbsig", WBsig_o, 0);
        chk("busy_err", err_o, 0);
        if (cyc == n_wait) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = rdata;
          #1;
          chk("ack_stall", stall_o, 0);
          sb.push_back('{wb, wr_en ? m_memdata : rdata, alu, rd, 2'b00});
          break;
        end else if (cyc == int'(TIMEOUT) - 1) begin
          #1;
          chk("tc_stall", stall_o, 0);
          sb.push_back('{2'b00, m_memdata, m_alu, m_rd, 2'b10});
        end else begin
          #1;
          chk("wait_stall", stall_o, 1);
        end
      end
    end
    @(negedge clk_i);
    drive_idle();
    chk("done_req", mem_req_o, 0);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("wb_out", WBsig_o, e.wb);
      chk("memdata_out", MemData_o, e.md);
      chk("alu_out", ALUdata_o, e.alu);
      chk("rd_out", RDaddr_o, e.rd);
      chk("err_out", err_o, e.err);
      m_memdata = e.md;
      m_alu     = e.alu;
      m_rd      = e.rd;
    end
  endtask

  initial begin
    rst_i = 1'b1;
    drive_idle();
    m_memdata = 32'h0;
    m_alu     = 32'h0;
    m_rd      = 5'd0;
    repeat (2) @(negedge clk_i);
    chk("rst_req", mem_req_o, 0);
    chk("rst_wb", WBsig_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_stall", stall_o, 0);
    rst_i = 1'b0;

    // Reset in the middle of an outstanding load.
    @(negedge clk_i);
    MemRead_i = 1'b1;
    ALUdata_i = 32'h0000_0100;
    RDaddr_i  = 5'd3;
    WBsig_i   = 2'b11;
    @(negedge clk_i);
    chk("pre_rst_req", mem_req_o, 1);
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_req", mem_req_o, 0);
    @(negedge clk_i);
    drive_idle();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_req", mem_req_o, 0);
    chk("post_rst_addr", mem_addr_o, 0);
    chk("post_rst_wb", WBsig_o, 0);
    chk("post_rst_md", MemData_o, 0);
    chk("post_rst_alu", ALUdata_o, 0);
    chk("post_rst_rd", RDaddr_o, 0);
    chk("post_rst_err", err_o, 0);

    // Non-memory op.
    run_op(1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 2'b10, 0, 32'h0);
    // Load with three wait cycles.
    run_op(1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd7, 2'b11, 3, 32'hDEAD_BEEF);
    // Store acked on the first BUSY cycle; MemData_o must hold.
    run_op(1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 5'd0, 2'b01, 0, 32'h1111_2222);
    // Misaligned load, then a nop to confirm err_o is a single pulse.
    run_op(1'b1, 1'b0, 32'h0000_0042, 32'h0, 5'd9, 2'b11, 0, 32'h0);
    run_op(1'b0, 1'b0, 32'h0000_0abc, 32'h0, 5'd10, 2'b01, 0, 32'h0);
    // Ack never arrives: timeout abort.
    run_op(1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd11, 2'b11, -1, 32'h0);
    // Ack in the terminal cycle: normal completion.
    run_op(1'b1, 1'b0, 32'h0000_0104, 32'h0, 5'd12, 2'b10, int'(TIMEOUT) - 1, 32'h1234_5678);
    // Read and write together behave as a store.
    run_op(1'b1, 1'b1, 32'h0000_00C0, 32'h0BAD_CAFE, 5'd13, 2'b01, 1, 32'h7777_7777);
    // Short load.
    run_op(1'b1, 1'b0, 32'h0000_0044, 32'h0, 5'd31, 2'b11, 1, 32'hA5A5_0F0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM stage of the pipelined CPU, between the EX/MEM and MEM/WB pipeline registers. It consumes EX/MEM outputs and performs word loads and stores through a variable-latency request/acknowledge data-memory port. It stalls the upstream pipeline while an access is outstanding and delivers a registered writeback bundle downstream. It also flags misaligned addresses and memory acknowledge timeouts.

## Interface
- TIMEOUT, 16, maximum cycles in BUSY waiting for mem_ack_i before the access is aborted (≥2)
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- WBsig_i  in  2  writeback control from EX/MEM
- MemRead_i  in  1  load request
- MemWrite_i  in  1  store request
- ALUdata_i  in  32  effective address / ALU result
- RS2data_i  in  32  store data
- RDaddr_i  in  5  destination register
- mem_req_o  out  1  memory request, level, held until ack or abort
- mem_we_o  out  1  1 = store, 0 = load
- mem_addr_o  out  32  word address (bits [1:0] always 0)
- mem_wdata_o  out  32  store data
- mem_ack_i  in  1  memory completion, one-cycle pulse
- mem_rdata_i  in  32  load data, valid when mem_ack_i=1
- stall_o  out  1  hold EX/MEM and everything upstream this cycle
- WBsig_o  out  2  registered writeback control (0 = bubble)
- MemData_o  out  32  registered load data
- ALUdata_o  out  32  registered ALU result
- RDaddr_o  out  5  registered destination
- err_o  out  2  registered, one-cycle pulse: bit0 misaligned, bit1 timeout

## Operation
- States: IDLE, BUSY.
- Access present = MemRead_i | MemWrite_i. If both are set, the access is a store.
- IDLE, no access: stall_o=0. On the edge, the outputs register takes WBsig_i, ALUdata_i, and RDaddr_i. MemData_o holds its value.
- IDLE, access with ALUdata_i[1:0]≠0: no request is issued and stall_o=0. On the edge: WBsig_o←0, err_o←2'b01, ALUdata_o and RDaddr_o are loaded.
- IDLE, aligned access: stall_o=1. On the edge: go to BUSY, latch addr, wdata, we, WBsig, and RDaddr; clear the wait counter; the outputs register takes a bubble (WBsig_o←0).
- BUSY: mem_req_o=1 and addr/we/wdata stay stable. stall_o = ~mem_ack_i.
  - Ack cycle edge: go to IDLE. WBsig_o←latched WBsig; MemData_o←mem_rdata_i (loads only, held for stores); ALUdata_o←latched addr; RDaddr_o←latched RD.
  - No ack: counter increments. When the counter reaches TIMEOUT−1 without ack, stall_o=0 that cycle. On the edge: go to IDLE, WBsig_o←0, err_o←2'b10.
- Ack and timeout in the same cycle: ack wins, no error.
- mem_ack_i while IDLE is ignored.
- err_o is 0 on every edge not listed above.

## Timing
- Reset (async, immediate): state IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, counter=0, WBsig_o=0, MemData_o=0, ALUdata_o=0, RDaddr_o=0, err_o=0. stall_o=0 after reset unless an access is present.
- Non-memory op: outputs valid 1 edge after arrival.
- Memory op: minimum 2 edges (arrival edge + ack edge). In general, 1 + N edges, where N is the BUSY cycles up to and including ack.
- mem_req_o is registered: it rises the cycle after the access arrives and falls on the edge after ack.
- stall_o is combinational from state, the access inputs, and mem_ack_i.
- Reset mid-BUSY drops mem_req_o at once and discards the access. No writeback and no error.

## Structure
- Shared package cpu_pkg: state enum (IDLE, BUSY), WB signal width (2), error bit indices (ERR_MISALIGN=0, ERR_TIMEOUT=1).
- One sub-module, mem_wait_timer: a counter with clear, enable, and a terminal-count flag at TIMEOUT−1, parameterised by TIMEOUT.

## Test plan
- Reset with MemRead_i=1 mid-BUSY → mem_req_o drops immediately; all outputs are 0 after release.
- Non-memory op, ALUdata_i=0x1234, RDaddr_i=5, WBsig_i=2'b10 → the next edge shows those values and stall_o stays 0 throughout.
- Load at addr 0x40, ack after 3 BUSY cycles with rdata 0xDEADBEEF → stall_o high for 4 cycles; then WBsig_o=WBsig_i, MemData_o=0xDEADBEEF, RDaddr_o correct; WBsig_o=0 during the stall.
- Store at addr 0x80, data 0xCAFEF00D, ack the first BUSY cycle → mem_we_o=1 with stable addr/data; completes in 2 edges; MemData_o unchanged.
- Load at addr 0x42 → no mem_req_o, err_o=2'b01 for one cycle, WBsig_o=0, no stall.
- Load with ack never arriving (TIMEOUT=16) → mem_req_o high for 16 cycles, then err_o=2'b10 and WBsig_o=0. Repeat with ack in the terminal cycle → normal completion and err_o=0.
